// File: rtl/mrv1_wb_arb.sv
// mrv1_wb_arb: writeback arbiter for the multithreaded register file write port.
// Each producer (ALU, LSU) feeds its own FIFO. One FIFO head is granted per cycle,
// round-robin on a tie. The winner is presented as a registered rd_* write.
// Writes to x0 use their slot but keep rd_w_en_o low.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   alu_valid_i / alu_ready_o    ALU handshake (ready = FIFO not full)
//   alu_twid_i, alu_rd_addr_i, alu_rd_data_i   ALU result packet
//   lsu_*                        same as alu_* for the LSU
//   rd_w_en_o, rd_twid_o, rd_addr_o, rd_data_o registered register-file write
module mrv1_wb_arb #(
  parameter int unsigned DATA_WIDTH_P    = 32,
  parameter int unsigned NUM_TW_P        = 8,
  parameter int unsigned rf_addr_width_p = 5,
  parameter int unsigned FIFO_DEPTH_P    = 2
) (
  input  logic                              clk_i,
  input  logic                              rst_i,

  input  logic                              alu_valid_i,
  output logic                              alu_ready_o,
  input  logic [$clog2(NUM_TW_P)-1:0]       alu_twid_i,
  input  logic [rf_addr_width_p-1:0]        alu_rd_addr_i,
  input  logic [DATA_WIDTH_P-1:0]           alu_rd_data_i,

  input  logic                              lsu_valid_i,
  output logic                              lsu_ready_o,
  input  logic [$clog2(NUM_TW_P)-1:0]       lsu_twid_i,
  input  logic [rf_addr_width_p-1:0]        lsu_rd_addr_i,
  input  logic [DATA_WIDTH_P-1:0]           lsu_rd_data_i,

  output logic                              rd_w_en_o,
  output logic [$clog2(NUM_TW_P)-1:0]       rd_twid_o,
  output logic [rf_addr_width_p-1:0]        rd_addr_o,
  output logic [DATA_WIDTH_P-1:0]           rd_data_o
);

  localparam int unsigned twid_width_lp = $clog2(NUM_TW_P);
  localparam int unsigned PTR_W         = $clog2(FIFO_DEPTH_P);
  localparam int unsigned CNT_W         = $clog2(FIFO_DEPTH_P + 1);
  localparam int unsigned NUM_SRC       = 2;   // index 0 = ALU, 1 = LSU

  typedef struct packed {
    logic [twid_width_lp-1:0]   twid;
    logic [rf_addr_width_p-1:0] addr;
    logic [DATA_WIDTH_P-1:0]    data;
  } wb_pkt_t;

  wb_pkt_t              mem       [NUM_SRC][FIFO_DEPTH_P];
  wb_pkt_t              wdata     [NUM_SRC];
  wb_pkt_t              head      [NUM_SRC];
  wb_pkt_t              head_sel;
  logic [PTR_W-1:0]     wr_ptr    [NUM_SRC];
  logic [PTR_W-1:0]     rd_ptr    [NUM_SRC];
  logic [CNT_W-1:0]     count     [NUM_SRC];
  logic [CNT_W-1:0]     count_nxt [NUM_SRC];
  logic [NUM_SRC-1:0]   ready;
  logic [NUM_SRC-1:0]   not_empty;
  logic [NUM_SRC-1:0]   push;
  logic [NUM_SRC-1:0]   pop;
  logic                 grant_alu;
  logic                 grant_lsu;
  logic                 last_lsu;   // 1 when the LSU won the most recent pop

  // Incoming packets and handshakes
  always_comb begin
    wdata[0] = '{twid: alu_twid_i, addr: alu_rd_addr_i, data: alu_rd_data_i};
    wdata[1] = '{twid: lsu_twid_i, addr: lsu_rd_addr_i, data: lsu_rd_data_i};
  end

  assign push        = {lsu_valid_i & ready[1], alu_valid_i & ready[0]};
  assign alu_ready_o = ready[0];
  assign lsu_ready_o = ready[1];

  // Round-robin: on a tie the source not granted last wins
  assign grant_alu = not_empty[0] & (~not_empty[1] | last_lsu);
  assign grant_lsu = not_empty[1] & ~grant_alu;
  assign pop       = {grant_lsu, grant_alu};
  assign head_sel  = grant_alu ? head[0] : head[1];

  // FIFO heads, occupancy and next count
  always_comb begin
    for (int s = 0; s < int'(NUM_SRC); s++) begin
      head[s]      = mem[s][rd_ptr[s]];
      not_empty[s] = (count[s] != '0);
      count_nxt[s] = count[s];
      case ({push[s], pop[s]})
        2'b10:   count_nxt[s] = count[s] + CNT_W'(1);
        2'b01:   count_nxt[s] = count[s] - CNT_W'(1);
        default: count_nxt[s] = count[s];
      endcase
    end
  end

  // FIFO storage; contents need no reset since count gates visibility
  always_ff @(posedge clk_i) begin
    for (int s = 0; s < int'(NUM_SRC); s++) begin
      if (push[s]) mem[s][wr_ptr[s]] <= wdata[s];
    end
  end

  // FIFO pointers, count and registered ready (not full after this edge)
  always_ff @(posedge clk_i) begin
    for (int s = 0; s < int'(NUM_SRC); s++) begin
      if (rst_i) begin
        wr_ptr[s] <= '0;
        rd_ptr[s] <= '0;
        count[s]  <= '0;
        ready[s]  <= 1'b1;
      end else begin
        if (push[s]) wr_ptr[s] <= wr_ptr[s] + PTR_W'(1);
        if (pop[s])  rd_ptr[s] <= rd_ptr[s] + PTR_W'(1);
        count[s] <= count_nxt[s];
        ready[s] <= (count_nxt[s] != CNT_W'(FIFO_DEPTH_P));
      end
    end
  end

  // Output register and grant history; idle cycles hold data, drop enable
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_lsu  <= 1'b1;
      rd_w_en_o <= 1'b0;
      rd_twid_o <= '0;
      rd_addr_o <= '0;
      rd_data_o <= '0;
    end else begin
      rd_w_en_o <= 1'b0;
      if (grant_alu | grant_lsu) begin
        last_lsu  <= grant_lsu;
        rd_w_en_o <= (head_sel.addr != '0);
        rd_twid_o <= head_sel.twid;
        rd_addr_o <= head_sel.addr;
        rd_data_o <= head_sel.data;
      end
    end
  end

endmodule

// File: tb/tb_mrv1_wb_arb.sv
// Testbench for mrv1_wb_arb: directed vector table, then queue-model-checked
// backpressure, reset and randomized traffic.
module tb_mrv1_wb_arb;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0, lsu_valid = 1'b0;
  logic        alu_ready, lsu_ready;
  logic [2:0]  alu_twid = '0, lsu_twid = '0;
  logic [4:0]  alu_addr = '0, lsu_addr = '0;
  logic [31:0] alu_data = '0, lsu_data = '0;
  logic        w_en;
  logic [2:0]  w_twid;
  logic [4:0]  w_addr;
  logic [31:0] w_data;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mrv1_wb_arb #(
    .DATA_WIDTH_P(32), .NUM_TW_P(8), .rf_addr_width_p(5), .FIFO_DEPTH_P(DEPTH)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .alu_valid_i(alu_valid), .alu_ready_o(alu_ready), .alu_twid_i(alu_twid),
    .alu_rd_addr_i(alu_addr), .alu_rd_data_i(alu_data),
    .lsu_valid_i(lsu_valid), .lsu_ready_o(lsu_ready), .lsu_twid_i(lsu_twid),
    .lsu_rd_addr_i(lsu_addr), .lsu_rd_data_i(lsu_data),
    .rd_w_en_o(w_en), .rd_twid_o(w_twid), .rd_addr_o(w_addr), .rd_data_o(w_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic rst;
    logic av; logic [2:0] atw; logic [4:0] ard; logic [31:0] ad;
    logic lv; logic [2:0] ltw; logic [4:0] lrd; logic [31:0] ld;
    logic ew; logic [2:0] etw; logic [4:0] ea; logic [31:0] ed;
    logic ear; logic elr;
  } vec_t;

  function automatic vec_t mk(input logic r,
      input logic av, input logic [2:0] atw, input logic [4:0] ard, input logic [31:0] ad,
      input logic lv, input logic [2:0] ltw, input logic [4:0] lrd, input logic [31:0] ld,
      input logic ew, input logic [2:0] etw, input logic [4:0] ea, input logic [31:0] ed,
      input logic ear, input logic elr);
    vec_t t;
    t.rst = r; t.av = av; t.atw = atw; t.ard = ard; t.ad = ad;
    t.lv = lv; t.ltw = ltw; t.lrd = lrd; t.ld = ld;
    t.ew = ew; t.etw = etw; t.ea = ea; t.ed = ed; t.ear = ear; t.elr = elr;
    return t;
  endfunction

  vec_t vecs[26];

  // ---------------- behavioural reference model ----------------
  typedef struct packed { logic [2:0] tw; logic [4:0] rd; logic [31:0] d; } pkt_t;

  pkt_t  aq[$];
  pkt_t  lq[$];
  logic  m_last_lsu = 1'b1;
  logic  m_w = 1'b0;
  pkt_t  m_out = '0;

  // One clock with the model: ready before the edge, outputs after it.
  task automatic mstep(input logic r, input logic av, input pkt_t ap,
                       input logic lv, input pkt_t lp,
                       output logic acc_a, output logic acc_l);
    int   na, nl;
    logic ga, gl;
    pkt_t p;
    na = aq.size();
    nl = lq.size();
    check("alu_ready", 32'(alu_ready), 32'(na < DEPTH));
    check("lsu_ready", 32'(lsu_ready), 32'(nl < DEPTH));
    ga = (na > 0) && ((nl == 0) || m_last_lsu);
    gl = (nl > 0) && !ga;
    rst = r;
    alu_valid = av; alu_twid = ap.tw; alu_addr = ap.rd; alu_data = ap.d;
    lsu_valid = lv; lsu_twid = lp.tw; lsu_addr = lp.rd; lsu_data = lp.d;
    @(posedge clk); #1;
    acc_a = 1'b0;
    acc_l = 1'b0;
    if (r) begin
      aq.delete(); lq.delete();
      m_last_lsu = 1'b1; m_w = 1'b0; m_out = '0;
    end else begin
      m_w = 1'b0;
      if (ga) begin p = aq.pop_front(); m_last_lsu = 1'b0; end
      else if (gl) begin p = lq.pop_front(); m_last_lsu = 1'b1; end
      if (ga || gl) begin m_out = p; m_w = (p.rd != 0); end
      acc_a = av && (na < DEPTH);
      acc_l = lv && (nl < DEPTH);
      if (acc_a) aq.push_back(ap);
      if (acc_l) lq.push_back(lp);
    end
    check("w_en", 32'(w_en), 32'(m_w));
    check("w_twid", 32'(w_twid), 32'(m_out.tw));
    check("w_addr", 32'(w_addr), 32'(m_out.rd));
    check("w_data", w_data, m_out.d);
  endtask

  function automatic pkt_t rand_pkt();
    pkt_t p;
    p.tw = 3'($urandom_range(0, 7));
    p.rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    p.d  = $urandom;
    return p;
  endfunction

  initial begin
    logic acc_a, acc_l, saw_low;
    pkt_t ap, lp;
    int   k, lk;

    // reset, single ALU write
    vecs[0]  = mk(1, 0,0,0,0,                 0,0,0,0,            0,0,0,0,            1,1);
    vecs[1]  = mk(0, 1,3,5,32'hDEADBEEF,      0,0,0,0,            0,0,0,0,            1,1);
    vecs[2]  = mk(0, 0,0,0,0,                 0,0,0,0,            1,3,5,32'hDEADBEEF, 1,1);
    vecs[3]  = mk(0, 0,0,0,0,                 0,0,0,0,            0,3,5,32'hDEADBEEF, 1,1);
    // tie-break from reset, then alternation under backpressure
    vecs[4]  = mk(1, 0,0,0,0,                 0,0,0,0,            0,0,0,0,            1,1);
    vecs[5]  = mk(0, 1,0,1,32'h11,            1,1,2,32'h22,       0,0,0,0,            1,1);
    vecs[6]  = mk(0, 1,0,1,32'hA1,            1,1,2,32'hB1,       1,0,1,32'h11,       1,0);
    vecs[7]  = mk(0, 1,0,1,32'hA2,            1,1,2,32'hB2,       1,1,2,32'h22,       0,1);
    vecs[8]  = mk(0, 1,0,1,32'hA3,            1,1,2,32'hB2,       1,0,1,32'hA1,       1,0);
    vecs[9]  = mk(0, 1,0,1,32'hA3,            1,1,2,32'hB3,       1,1,2,32'hB1,       0,1);
    vecs[10] = mk(0, 0,0,0,0,                 1,1,2,32'hB3,       1,0,1,32'hA2,       1,0);
    vecs[11] = mk(0, 0,0,0,0,                 0,0,0,0,            1,1,2,32'hB2,       1,1);
    vecs[12] = mk(0, 0,0,0,0,                 0,0,0,0,            1,0,1,32'hA3,       1,1);
    vecs[13] = mk(0, 0,0,0,0,                 0,0,0,0,            1,1,2,32'hB3,       1,1);
    vecs[14] = mk(0, 0,0,0,0,                 0,0,0,0,            0,1,2,32'hB3,       1,1);
    // x0 drop
    vecs[15] = mk(0, 0,0,0,0,                 1,2,0,32'h55,       0,1,2,32'hB3,       1,1);
    vecs[16] = mk(0, 0,0,0,0,                 1,2,7,32'h66,       0,2,0,32'h55,       1,1);
    vecs[17] = mk(0, 0,0,0,0,                 0,0,0,0,            1,2,7,32'h66,       1,1);
    vecs[18] = mk(0, 0,0,0,0,                 0,0,0,0,            0,2,7,32'h66,       1,1);
    // reset mid-operation with buffered entries and a push in the reset cycle
    vecs[19] = mk(0, 1,4,9,32'h99,            1,5,10,32'hAA,      0,2,7,32'h66,       1,1);
    vecs[20] = mk(0, 1,4,9,32'h9A,            1,5,10,32'hAB,      1,4,9,32'h99,       1,0);
    vecs[21] = mk(1, 1,4,9,32'h9B,            0,0,0,0,            0,0,0,0,            1,1);
    vecs[22] = mk(0, 0,0,0,0,                 0,0,0,0,            0,0,0,0,            1,1);
    vecs[23] = mk(0, 1,6,3,32'h123,           0,0,0,0,            0,0,0,0,            1,1);
    vecs[24] = mk(0, 0,0,0,0,                 0,0,0,0,            1,6,3,32'h123,      1,1);
    vecs[25] = mk(0, 0,0,0,0,                 0,0,0,0,            0,6,3,32'h123,      1,1);

    for (int i = 0; i < 26; i++) begin
      rst = vecs[i].rst;
      alu_valid = vecs[i].av; alu_twid = vecs[i].atw; alu_addr = vecs[i].ard; alu_data = vecs[i].ad;
      lsu_valid = vecs[i].lv; lsu_twid = vecs[i].ltw; lsu_addr = vecs[i].lrd; lsu_data = vecs[i].ld;
      @(posedge clk); #1;
      check($sformatf("vec%0d_w_en", i),   32'(w_en),      32'(vecs[i].ew));
      check($sformatf("vec%0d_twid", i),   32'(w_twid),    32'(vecs[i].etw));
      check($sformatf("vec%0d_addr", i),   32'(w_addr),    32'(vecs[i].ea));
      check($sformatf("vec%0d_data", i),   w_data,         vecs[i].ed);
      check($sformatf("vec%0d_aready", i), 32'(alu_ready), 32'(vecs[i].ear));
      check($sformatf("vec%0d_lready", i), 32'(lsu_ready), 32'(vecs[i].elr));
    end

    // Backpressure: ALU holds each packet until accepted, LSU floods
    mstep(1, 0, '0, 0, '0, acc_a, acc_l);
    k = 0; lk = 0; saw_low = 1'b0;
    for (int c = 0; c < 60 && k < DEPTH + 3; c++) begin
      ap = '{tw: 3'd1, rd: 5'd4, d: 32'hA000_0000 + 32'(k)};
      lp = '{tw: 3'd2, rd: 5'd6, d: 32'hB000_0000 + 32'(lk)};
      if (!alu_ready) saw_low = 1'b1;
      mstep(0, 1, ap, 1, lp, acc_a, acc_l);
      if (acc_a) k++;
      if (acc_l) lk++;
    end
    check("bp_alu_pushes", 32'(k), 32'(DEPTH + 3));
    check("bp_alu_ready_dropped", 32'(saw_low), 32'd1);
    for (int c = 0; c < 2 * DEPTH + 4; c++) mstep(0, 0, '0, 0, '0, acc_a, acc_l);
    check("bp_drained", 32'(aq.size() + lq.size()), 32'd0);

    // Randomized traffic with occasional resets
    ap = rand_pkt();
    lp = rand_pkt();
    for (int c = 0; c < 400; c++) begin
      mstep(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 6), ap,
            ($urandom_range(0, 9) < 6), lp, acc_a, acc_l);
      if (acc_a) ap = rand_pkt();
      if (acc_l) lp = rand_pkt();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
